divider_result_fifo: RTL and testbench
======================================

Name: divider_result_fifo

Overview:
- Output stage directly downstream of the last divider_cell in the pipelined divider chain.
- Captures each quotient/remainder pair the pipeline produces.
- Optionally rounds the quotient to nearest and flags divide-by-zero.
- Buffers results in a small FIFO with a valid/ready interface, because the divider pipeline cannot stall; lost words are reported through a sticky overflow flag.

Parameters:
- WIDTH_DIVIDEND, 5, quotient width; matches the divider chain.
- WIDTH_DIVISOR, 3, divisor/remainder width; matches the divider chain.
- FIFO_DEPTH, 4, result buffer entries; power of two, ≥2.
- ROUND_EN, 1, 1 = round quotient to nearest, 0 = truncate.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- in_vld  in  1  result valid; driven by rdy of the last divider cell.
- in_quot  in  WIDTH_DIVIDEND  quotient; driven by result_o of the last cell.
- in_rem  in  WIDTH_DIVISOR  remainder; driven by remainder of the last cell.
- in_divisor  in  WIDTH_DIVISOR  divisor carried alongside the result; driven by divisor_kp of the last cell.
- out_rdy  in  1  downstream ready.
- ovf_clr  in  1  clears the sticky overflow flag.
- out_vld  out  1  FIFO head valid.
- out_quot  out  WIDTH_DIVIDEND  quotient at the FIFO head.
- out_rem  out  WIDTH_DIVISOR  remainder at the FIFO head.
- out_dz  out  1  head entry was a divide-by-zero.
- ovf  out  1  sticky: at least one result dropped.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, sampled on the clk edge while arst_n=0. Clears the stage-1 register, FIFO pointers, level, ovf and out_vld. out_quot, out_rem and out_dz read 0 after reset.
- A reset asserted mid-stream discards all buffered and in-flight results. There is no partial flush.

Stage 1 (registered, captures every cycle in_vld=1):
- Divide-by-zero, in_divisor==0:
  - q = all ones, r = 0, dz = 1.
- Otherwise:
  - r = in_rem, dz = 0.
  - Round-up is true when ROUND_EN=1 and {in_rem,1'b0} ≥ {1'b0,in_divisor}. The comparison is WIDTH_DIVISOR+1 bits wide, with no overflow.
  - If round-up is true, q = in_quot+1, saturating at all ones. Otherwise q = in_quot.
- Remainder is not adjusted by rounding.
- s1_vld follows in_vld one cycle later.

FIFO:
- push = s1_vld; pop = out_vld & out_rdy.
- Written word is {dz, r, q}. Read pointer and write pointer wrap modulo FIFO_DEPTH.
- Head outputs are read from the entry at the read pointer.
- out_vld = (level != 0).
- Latency: in_vld at edge N is captured into stage 1 at edge N. It is written to the FIFO at edge N+1. out_vld rises after edge N+1 when the FIFO was empty (2 cycles).
- Simultaneous push and pop:
  - Allowed at any level, including full. Level is unchanged and both pointers advance.
- Push when full with no pop:
  - The new word is dropped and FIFO contents are untouched.
  - ovf is set at the next edge.
- Pop when empty: impossible, because out_vld=0 while empty.
- ovf is cleared by ovf_clr. If a drop and ovf_clr occur in the same cycle, set wins (ovf=1).
- Outputs are stable while out_vld=1 and out_rdy=0.
- Throughput: one result per cycle, sustained, while out_rdy=1.

Test Plan:
- Reset with arst_n=0 for 2 cycles → out_vld=0, level=0, ovf=0, out_quot=0. Then apply in_vld=1, in_quot=4, in_rem=1, in_divisor=3 (13/3) → after 2 cycles out_vld=1, out_quot=4, out_rem=1, out_dz=0.
- Rounding, ROUND_EN=1:
  - quot=4, rem=2, div=3 (14/3) → out_quot=5, out_rem=2.
  - quot=4, rem=1, div=2 (9/2, exact half) → out_quot=5.
  - With ROUND_EN=0, the same 9/2 input → out_quot=4.
- Saturation and zero divisor:
  - quot=31, rem=2, div=3 → out_quot=31.
  - div=0 with quot=31 → out_quot=31, out_rem=0, out_dz=1.
- Backpressure and overflow: hold out_rdy=0 and push 6 consecutive results with quot=1..6. Then:
  - level saturates at 4 and ovf=1.
  - Releasing out_rdy drains 1,2,3,4 in order; results 5 and 6 are lost.
  - ovf stays 1 until ovf_clr.
- Full with simultaneous push and pop: fill to 4, then hold out_rdy=1 with a continuous input stream → level stays 4, no ovf, and output order matches input order across a pointer wrap.
- Reset mid-stream: with level=3, drive arst_n=0 for one edge → level=0 and out_vld=0. The next input appears 2 cycles after reset release with its correct value.

Source files
------------

// File: rtl/divider_result_fifo_if.sv
// Result bus between the divider output stage and its consumer: pipeline-side
// inputs, the valid/ready head of the result FIFO, and the status flags.
interface divider_result_fifo_if #(
  parameter int unsigned WIDTH_DIVIDEND = 5,
  parameter int unsigned WIDTH_DIVISOR  = 3,
  parameter int unsigned FIFO_DEPTH     = 4
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic                      in_vld;
  logic [WIDTH_DIVIDEND-1:0] in_quot;
  logic [WIDTH_DIVISOR-1:0]  in_rem;
  logic [WIDTH_DIVISOR-1:0]  in_divisor;
  logic                      out_rdy;
  logic                      ovf_clr;
  logic                      out_vld;
  logic [WIDTH_DIVIDEND-1:0] out_quot;
  logic [WIDTH_DIVISOR-1:0]  out_rem;
  logic                      out_dz;
  logic                      ovf;
  logic [LvlW-1:0]           level;

  modport master (
    output in_vld, in_quot, in_rem, in_divisor, out_rdy, ovf_clr,
    input  out_vld, out_quot, out_rem, out_dz, ovf, level
  );

  modport slave (
    input  in_vld, in_quot, in_rem, in_divisor, out_rdy, ovf_clr,
    output out_vld, out_quot, out_rem, out_dz, ovf, level
  );
endinterface

// File: rtl/divider_result_fifo.sv
// Output stage of the pipelined divider: rounds/flags each result, then buffers
// it in a small valid/ready FIFO. The pipeline cannot stall, so drops set ovf.
module divider_result_fifo #(
  parameter int unsigned WIDTH_DIVIDEND = 5,
  parameter int unsigned WIDTH_DIVISOR  = 3,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter bit          ROUND_EN       = 1'b1
) (
  input logic                    clk,
  input logic                    arst_n,
  divider_result_fifo_if.slave   bus_io
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned WordW = 1 + WIDTH_DIVISOR + WIDTH_DIVIDEND;

  typedef logic [WordW-1:0] word_t;

  // Stage 1: rounding and divide-by-zero substitution
  logic                      s1_vld_q;
  logic [WIDTH_DIVIDEND-1:0] s1_q_q, s1_q_d;
  logic [WIDTH_DIVISOR-1:0]  s1_r_q, s1_r_d;
  logic                      s1_dz_q, s1_dz_d;
  logic                      round_up;

  always_comb begin
    s1_q_d   = bus_io.in_quot;
    s1_r_d   = bus_io.in_rem;
    s1_dz_d  = 1'b0;
    round_up = 1'b0;
    if (bus_io.in_divisor == '0) begin
      s1_q_d  = '1;
      s1_r_d  = '0;
      s1_dz_d = 1'b1;
    end else begin
      // Twice the remainder against the divisor, one bit wider so it cannot wrap.
      round_up = ROUND_EN && ({bus_io.in_rem, 1'b0} >= {1'b0, bus_io.in_divisor});
      if (round_up && (bus_io.in_quot != '1)) begin
        s1_q_d = bus_io.in_quot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      s1_vld_q <= 1'b0;
      s1_q_q   <= '0;
      s1_r_q   <= '0;
      s1_dz_q  <= 1'b0;
    end else begin
      s1_vld_q <= bus_io.in_vld;
      if (bus_io.in_vld) begin
        s1_q_q  <= s1_q_d;
        s1_r_q  <= s1_r_d;
        s1_dz_q <= s1_dz_d;
      end
    end
  end

  // Result FIFO
  word_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, full, wr_en, drop;

  assign push  = s1_vld_q;
  assign pop   = bus_io.out_vld & bus_io.out_rdy;
  assign full  = (level_q == LvlW'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the head slot, which is the write slot.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    level_d  = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !wr_en) begin
      level_d = level_q - LvlW'(1);
    end
    ovf_d = drop | (ovf_q & ~bus_io.ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {s1_dz_q, s1_r_q, s1_q_q};
      end
    end
  end

  assign {bus_io.out_dz, bus_io.out_rem, bus_io.out_quot} = mem_q[rd_ptr_q];
  assign bus_io.out_vld = (level_q != '0);
  assign bus_io.ovf     = ovf_q;
  assign bus_io.level   = level_q;
endmodule

// File: tb/tb_divider_result_fifo.sv
// Directed bench for divider_result_fifo: a rounding DUT and a truncating DUT
// share one stimulus stream; FIFO corner cases are hand-sequenced.
module tb_divider_result_fifo;
  logic clk;
  logic arst_n;
  int   checks   = 0;
  int   failures = 0;

  divider_result_fifo_if #(.WIDTH_DIVIDEND(5), .WIDTH_DIVISOR(3), .FIFO_DEPTH(4)) bus0 ();
  divider_result_fifo_if #(.WIDTH_DIVIDEND(5), .WIDTH_DIVISOR(3), .FIFO_DEPTH(4)) bus1 ();

  assign bus1.in_vld     = bus0.in_vld;
  assign bus1.in_quot    = bus0.in_quot;
  assign bus1.in_rem     = bus0.in_rem;
  assign bus1.in_divisor = bus0.in_divisor;
  assign bus1.out_rdy    = bus0.out_rdy;
  assign bus1.ovf_clr    = bus0.ovf_clr;

  divider_result_fifo #(
    .WIDTH_DIVIDEND(5), .WIDTH_DIVISOR(3), .FIFO_DEPTH(4), .ROUND_EN(1'b1)
  ) u_dut_rnd (
    .clk    (clk),
    .arst_n (arst_n),
    .bus_io (bus0)
  );

  divider_result_fifo #(
    .WIDTH_DIVIDEND(5), .WIDTH_DIVISOR(3), .FIFO_DEPTH(4), .ROUND_EN(1'b0)
  ) u_dut_trn (
    .clk    (clk),
    .arst_n (arst_n),
    .bus_io (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input int q, input int r, input int d);
    bus0.in_vld     = vld;
    bus0.in_quot    = 5'(q);
    bus0.in_rem     = 3'(r);
    bus0.in_divisor = 3'(d);
  endtask

  typedef struct {
    int quot;
    int rem;
    int div;
    int exp_q;
    int exp_r;
    int exp_dz;
    int exp_q_trn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_next;
    vecs[0] = '{4, 1, 3, 4, 1, 0, 4};     // 13/3, below half
    vecs[1] = '{4, 2, 3, 5, 2, 0, 4};     // 14/3 rounds up
    vecs[2] = '{4, 1, 2, 5, 1, 0, 4};     // 9/2 exact half
    vecs[3] = '{31, 2, 3, 31, 2, 0, 31};  // saturation
    vecs[4] = '{31, 5, 0, 31, 0, 1, 31};  // divide by zero
    vecs[5] = '{5, 3, 0, 31, 0, 1, 31};   // divide by zero, other operands
    vecs[6] = '{6, 3, 7, 6, 3, 0, 6};     // 6 < 7, no round
    vecs[7] = '{10, 4, 7, 11, 4, 0, 10};  // 8 >= 7 rounds up

    arst_n       = 1'b0;
    bus0.out_rdy = 1'b0;
    bus0.ovf_clr = 1'b0;
    drive(1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_vld", int'(bus0.out_vld), 0);
    chk("reset level", int'(bus0.level), 0);
    chk("reset ovf", int'(bus0.ovf), 0);
    chk("reset out_quot", int'(bus0.out_quot), 0);
    chk("reset out_rem", int'(bus0.out_rem), 0);
    chk("reset out_dz", int'(bus0.out_dz), 0);
    arst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].quot, vecs[i].rem, vecs[i].div);
      @(negedge clk);
      drive(1'b0, 0, 0, 0);
      chk($sformatf("vec%0d early out_vld", i), int'(bus0.out_vld), 0);
      @(negedge clk);
      chk($sformatf("vec%0d out_vld", i), int'(bus0.out_vld), 1);
      chk($sformatf("vec%0d out_quot", i), int'(bus0.out_quot), vecs[i].exp_q);
      chk($sformatf("vec%0d out_rem", i), int'(bus0.out_rem), vecs[i].exp_r);
      chk($sformatf("vec%0d out_dz", i), int'(bus0.out_dz), vecs[i].exp_dz);
      chk($sformatf("vec%0d trunc out_quot", i), int'(bus1.out_quot), vecs[i].exp_q_trn);
      bus0.out_rdy = 1'b1;
      @(negedge clk);
      bus0.out_rdy = 1'b0;
      chk($sformatf("vec%0d level after pop", i), int'(bus0.level), 0);
    end

    // Overflow: six pushes under backpressure; ovf_clr held through the last drop.
    bus0.ovf_clr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, k, 0, 3);
      @(negedge clk);
    end
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    bus0.ovf_clr = 1'b0;
    chk("ovf level full", int'(bus0.level), 4);
    chk("ovf set wins over clr", int'(bus0.ovf), 1);
    @(negedge clk);
    bus0.out_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d out_vld", k), int'(bus0.out_vld), 1);
      chk($sformatf("drain%0d out_quot", k), int'(bus0.out_quot), k);
      @(negedge clk);
    end
    bus0.out_rdy = 1'b0;
    chk("drained out_vld", int'(bus0.out_vld), 0);
    chk("ovf sticky", int'(bus0.ovf), 1);
    bus0.ovf_clr = 1'b1;
    @(negedge clk);
    bus0.ovf_clr = 1'b0;
    chk("ovf cleared", int'(bus0.ovf), 0);

    // Full FIFO with simultaneous push and pop across a pointer wrap.
    for (int c = 1; c <= 12; c++) begin
      if (c >= 6) begin
        chk($sformatf("stream c%0d level", c), int'(bus0.level), 4);
        chk($sformatf("stream c%0d out_quot", c), int'(bus0.out_quot), c - 5);
      end
      bus0.out_rdy = (c >= 6);
      drive(1'b1, c, 0, 3);
      @(negedge clk);
    end
    drive(1'b0, 0, 0, 0);
    exp_next = 8;
    for (int t = 0; t < 20; t++) begin
      if (bus0.out_vld) begin
        chk($sformatf("stream tail q%0d", exp_next), int'(bus0.out_quot), exp_next);
        exp_next++;
      end
      @(negedge clk);
    end
    chk("stream tail count", exp_next, 13);
    chk("stream no ovf", int'(bus0.ovf), 0);
    bus0.out_rdy = 1'b0;

    // Reset mid-stream discards buffered results.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, k, 0, 3);
      @(negedge clk);
    end
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("pre-reset level", int'(bus0.level), 3);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    chk("mid reset level", int'(bus0.level), 0);
    chk("mid reset out_vld", int'(bus0.out_vld), 0);
    drive(1'b1, 9, 1, 3);
    @(negedge clk);
    drive(1'b0, 0, 0, 0);
    @(negedge clk);
    chk("post reset out_vld", int'(bus0.out_vld), 1);
    chk("post reset out_quot", int'(bus0.out_quot), 9);
    chk("post reset level", int'(bus0.level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
